// File: rtl/fire2_expand1_mac.sv
// -----------------------------------------------------------------------------
// fire2_expand1_mac
//
// Purpose:
//   The expand1x1 stage of a SqueezeNet fire module for one pixel. Each of the
//   2**ADDR squeeze activations of a pixel arrives as one beat. On every beat,
//   NUM parallel lanes multiply the activation by that lane's weight from an
//   external combinational ROM and accumulate the products. When the last
//   channel has been accepted, the sums are rescaled from Q(2*FRAC) back to
//   Q(FRAC), passed through ReLU, saturated to WIDTH bits, and held until the
//   downstream stage takes them.
//
//   Sequence: ACC (accept beats) -> ROUND (one cycle, register results)
//             -> HOLD (present results) -> ACC.
//
// Ports:
//   clk        in   sole clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   act_in     in   WIDTH       signed activation for input channel 'address'
//   act_valid  in   1           act_in valid
//   act_ready  out  1           high only in ACC; a beat is valid & ready
//   address    out  ADDR        input-channel counter, drives the weight ROM
//   weights    in   WIDTH x NUM ROM data for 'address', one word per lane
//   out_data   out  WIDTH x NUM result of one pixel, stable during HOLD
//   out_valid  out  1           high only in HOLD
//   out_ready  in   1           downstream accepts out_data (ignored outside HOLD)
// -----------------------------------------------------------------------------
module fire2_expand1_mac #(
    parameter int WIDTH = 16,
    parameter int ADDR  = 4,
    parameter int NUM   = 64,
    parameter int FRAC  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic signed [WIDTH-1:0] act_in,
    input  logic                    act_valid,
    output logic                    act_ready,
    output logic [ADDR-1:0]         address,
    input  logic signed [WIDTH-1:0] weights  [0:NUM-1],
    output logic signed [WIDTH-1:0] out_data [0:NUM-1],
    output logic                    out_valid,
    input  logic                    out_ready
);

    // A full pixel sum of 2**ADDR products of two WIDTH-bit values cannot
    // overflow this width.
    localparam int ACCW = 2 * WIDTH + ADDR;

    // Largest positive WIDTH-bit value, at accumulator width and output width.
    localparam logic signed [ACCW-1:0]  SAT_MAX   = {{(ACCW - WIDTH + 1){1'b0}}, {(WIDTH - 1){1'b1}}};
    localparam logic signed [WIDTH-1:0] SAT_MAX_W = {1'b0, {(WIDTH - 1){1'b1}}};

    typedef enum logic [1:0] {
        ACC,
        ROUND,
        HOLD
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR-1:0]         addr_q,  addr_d;
    logic signed [ACCW-1:0]  acc_q    [0:NUM-1];
    logic signed [ACCW-1:0]  acc_d    [0:NUM-1];
    logic signed [WIDTH-1:0] out_q    [0:NUM-1];
    logic signed [WIDTH-1:0] out_d    [0:NUM-1];
    logic                    beat;

    // Rescale to Q(FRAC) with floor (arithmetic shift), clamp negatives to
    // zero, clamp large positives to the largest representable value.
    function automatic logic signed [WIDTH-1:0] relu_sat(input logic signed [ACCW-1:0] acc);
        logic signed [ACCW-1:0] shifted;
        shifted = acc >>> FRAC;
        if (shifted < 0)
            relu_sat = '0;
        else if (shifted > SAT_MAX)
            relu_sat = SAT_MAX_W;
        else
            relu_sat = WIDTH'(shifted);
    endfunction

    assign act_ready = (state_q == ACC);
    assign out_valid = (state_q == HOLD);
    assign address   = addr_q;
    assign out_data  = out_q;
    assign beat      = act_valid && act_ready;

    // NOTE: every variable written here gets its hold value first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        acc_d   = acc_q;
        out_d   = out_q;

        unique case (state_q)
            ACC: begin
                if (beat) begin
                    addr_d = addr_q + ADDR'(1);
                    for (int i = 0; i < NUM; i++) begin
                        // Channel 0 starts a new pixel: overwrite instead of add,
                        // so no explicit clear cycle is needed between pixels.
                        if (addr_q == '0)
                            acc_d[i] = ACCW'(act_in) * ACCW'(weights[i]);
                        else
                            acc_d[i] = acc_q[i] + ACCW'(act_in) * ACCW'(weights[i]);
                    end
                    if (addr_q == '1)
                        state_d = ROUND;
                end
            end
            ROUND: begin
                for (int i = 0; i < NUM; i++)
                    out_d[i] = relu_sat(acc_q[i]);
                state_d = HOLD;
            end
            HOLD: begin
                if (out_ready)
                    state_d = ACC;
            end
            default: state_d = ACC;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    // NOTE: the accumulator and output arrays are reset too, because a reset
    // must discard partial sums and pending results and out_data must read 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACC;
            addr_q  <= '0;
            acc_q   <= '{default: '0};
            out_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            acc_q   <= acc_d;
            out_q   <= out_d;
        end
    end

endmodule

// File: tb/tb_fire2_expand1_mac.sv
// -----------------------------------------------------------------------------
// tb_fire2_expand1_mac
//
// Drives whole pixels into fire2_expand1_mac and compares address, handshake
// and every output lane against a reference model that computes each lane as
// an integer dot product over the pixel's channels, then floor-divides by
// 2**FRAC and clamps to [0, 2**(WIDTH-1)-1]. Inputs change 1 time unit after
// a rising edge; outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_fire2_expand1_mac;

    localparam int WIDTH = 16;
    localparam int ADDR  = 4;
    localparam int NUM   = 64;
    localparam int FRAC  = 8;
    localparam int NCH   = 1 << ADDR;

    logic                    clk;
    logic                    rst_n;
    logic signed [WIDTH-1:0] act_in;
    logic                    act_valid;
    logic                    act_ready;
    logic [ADDR-1:0]         address;
    logic signed [WIDTH-1:0] weights  [0:NUM-1];
    logic signed [WIDTH-1:0] out_data [0:NUM-1];
    logic                    out_valid;
    logic                    out_ready;

    // Weight ROM image: rom[channel][lane], read combinationally by address.
    logic signed [WIDTH-1:0] rom  [0:NCH-1][0:NUM-1];
    logic signed [WIDTH-1:0] acts [NCH];
    logic signed [WIDTH-1:0] exp_lane [NUM];

    int n_vec  = 0;
    int n_miss = 0;

    fire2_expand1_mac #(
        .WIDTH(WIDTH), .ADDR(ADDR), .NUM(NUM), .FRAC(FRAC)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .act_in   (act_in),
        .act_valid(act_valid),
        .act_ready(act_ready),
        .address  (address),
        .weights  (weights),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    always_comb begin
        for (int i = 0; i < NUM; i++)
            weights[i] = rom[address][i];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    task automatic check(input string tag, input longint got, input longint exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Reference: sum of products over all channels, floor(/2**FRAC), ReLU, saturate.
    task automatic compute_expected();
        longint sum, q, lim;
        lim = (longint'(1) << (WIDTH - 1)) - 1;
        for (int l = 0; l < NUM; l++) begin
            sum = 0;
            for (int c = 0; c < NCH; c++)
                sum += longint'(acts[c]) * longint'(rom[c][l]);
            q = sum >>> FRAC;
            if (q < 0)        q = 0;
            else if (q > lim) q = lim;
            exp_lane[l] = WIDTH'(q);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_rom_const(input logic signed [WIDTH-1:0] w);
        for (int c = 0; c < NCH; c++)
            for (int l = 0; l < NUM; l++)
                rom[c][l] = w;
    endtask

    task automatic fill_acts_const(input logic signed [WIDTH-1:0] a);
        for (int c = 0; c < NCH; c++)
            acts[c] = a;
    endtask

    task automatic check_lanes(input string tag);
        for (int l = 0; l < NUM; l++)
            check($sformatf("%s_lane%0d", tag, l), out_data[l], exp_lane[l]);
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_ready"}, act_ready, 1);
        check({tag, "_addr"},  address,   0);
        for (int l = 0; l < NUM; l++)
            check($sformatf("%s_out%0d", tag, l), out_data[l], 0);
    endtask

    // Send the first nbeats channels of acts. gap_mode: 0 back-to-back,
    // 1 one idle cycle before every beat, 2 random idle cycles.
    // out_ready is randomised throughout: it must have no effect in ACC.
    task automatic send_pixel(input int gap_mode, input int nbeats);
        int idle;
        for (int c = 0; c < nbeats; c++) begin
            idle = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
            for (int g = 0; g < idle; g++) begin
                act_valid = 1'b0;
                act_in    = WIDTH'($urandom);
                out_ready = 1'($urandom);
                tick();
                check("gap_addr", address, c);
            end
            act_valid = 1'b1;
            act_in    = acts[c];
            out_ready = 1'($urandom);
            check("beat_addr",  address,   c);
            check("beat_ready", act_ready, 1);
            check("beat_valid", out_valid, 0);
            tick();
        end
        act_valid = 1'b0;
        out_ready = 1'b0;
    endtask

    // Called right after the edge accepting the last beat: one ROUND cycle,
    // then HOLD for hold_cycles extra cycles with out_ready low, then release.
    // act_valid is driven high during ROUND/HOLD; no beat may be taken.
    task automatic finish_pixel(input string tag, input int hold_cycles);
        check({tag, "_round_valid"}, out_valid, 0);
        check({tag, "_round_ready"}, act_ready, 0);
        act_valid = 1'b1;
        act_in    = WIDTH'($urandom);
        out_ready = 1'b0;
        tick();
        for (int h = 0; h <= hold_cycles; h++) begin
            check({tag, "_hold_valid"}, out_valid, 1);
            check({tag, "_hold_ready"}, act_ready, 0);
            check({tag, "_hold_addr"},  address,   0);
            check_lanes(tag);
            if (h < hold_cycles) begin
                act_in = WIDTH'($urandom);
                tick();
            end
        end
        out_ready = 1'b1;
        tick();
        act_valid = 1'b0;
        out_ready = 1'b0;
        check({tag, "_rel_valid"}, out_valid, 0);
        check({tag, "_rel_ready"}, act_ready, 1);
        check({tag, "_rel_addr"},  address,   0);
    endtask

    task automatic run_pixel(input string tag, input int gap_mode, input int hold_cycles);
        compute_expected();
        send_pixel(gap_mode, NCH);
        finish_pixel(tag, hold_cycles);
    endtask

    function automatic logic signed [WIDTH-1:0] rand_val();
        logic signed [WIDTH-1:0] v;
        v = WIDTH'($urandom);
        return v >>> $urandom_range(0, 9);
    endfunction

    initial begin
        rst_n     = 1'b0;
        act_in    = '0;
        act_valid = 1'b0;
        out_ready = 1'b0;
        fill_rom_const(16'sh0100);
        fill_acts_const(16'sh0100);

        // Reset state with the clock running.
        tick();
        tick();
        check_idle_zero("reset");
        #3 rst_n = 1'b1;
        tick();

        // Unity weights and activations: 16 * 1.0 * 1.0 = 16.0 = 0x1000.
        fill_rom_const(16'sh0100);
        fill_acts_const(16'sh0100);
        run_pixel("unity", 0, 0);
        for (int l = 0; l < NUM; l++)
            check("unity_const", exp_lane[l], 16'sh1000);

        // Negative weights: ReLU clamps to zero.
        fill_rom_const(16'shFF00);
        fill_acts_const(16'sh0100);
        run_pixel("relu", 0, 0);

        // Largest positive weights and activations: saturate.
        fill_rom_const(16'sh7FFF);
        fill_acts_const(16'sh7FFF);
        run_pixel("sat", 0, 0);

        // Lane-dependent weights, act_valid toggling: lane i = i*0x10.
        for (int c = 0; c < NCH; c++)
            for (int l = 0; l < NUM; l++)
                rom[c][l] = WIDTH'(l * 16);
        fill_acts_const(16'sh0100);
        run_pixel("ramp", 1, 0);

        // Long HOLD with backpressure, then a following pixel.
        fill_rom_const(16'sh0100);
        fill_acts_const(16'sh0100);
        run_pixel("hold", 0, 10);
        fill_acts_const(16'sh0080);
        run_pixel("after_hold", 0, 0);

        // Reset after beat 7, asserted and released between clock edges.
        fill_acts_const(16'sh7FFF);
        send_pixel(0, 8);
        check("mid_addr", address, 8);
        #2 rst_n = 1'b0;
        #1;
        check_idle_zero("midrst");
        tick();
        #3 rst_n = 1'b1;
        tick();
        check_idle_zero("midrst_rel");
        fill_rom_const(16'sh0100);
        fill_acts_const(16'sh0100);
        run_pixel("post_rst", 0, 0);

        // Reset while holding a result.
        compute_expected();
        send_pixel(0, NCH);
        tick();
        check("hrst_valid", out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check_idle_zero("hold_rst");
        #3 rst_n = 1'b1;
        tick();

        // Random ROM contents, activations, gaps and backpressure.
        for (int p = 0; p < 12; p++) begin
            for (int c = 0; c < NCH; c++) begin
                acts[c] = rand_val();
                for (int l = 0; l < NUM; l++)
                    rom[c][l] = rand_val();
            end
            run_pixel($sformatf("rnd%0d", p), 2, int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
